// File: rtl/scs8hd_o2xa_pipe.sv
// Pipelined multi-channel OR-AND cell: X[c] = |A[c*NOR +: NOR] & B1[c], valid/ready on both sides.
// Optional saturating count of non-zero delivered beats under SCS8HD_O2XA_PIPE_CNT_EN.
module scs8hd_o2xa_pipe #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NOR    = 2,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [WIDTH*NOR-1:0] A,
  input  logic [WIDTH-1:0]     B1,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [WIDTH-1:0]     X,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY
`ifdef SCS8HD_O2XA_PIPE_CNT_EN
  ,
  output logic [CNT_W-1:0]     BEATS
`endif
);

  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("scs8hd_o2xa_pipe: STAGES must be 1 or 2");
  end
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("scs8hd_o2xa_pipe: CNT_W must be at least 1");
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  or_red;
  logic [WIDTH-1:0]  x_q;
  logic              all_v;

  always_comb begin
    for (int c = 0; c < int'(WIDTH); c++) begin
      or_red[c] = |A[c*NOR +: NOR];
    end
  end

  // Stage k is ready when downstream accepts or any stage from k onward is empty.
  // Written as a running AND so the chain has no combinational self-reference.
  always_comb begin
    all_v = 1'b1;
    rdy   = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      all_v  = all_v & v_q[k];
      rdy[k] = OUT_READY | !all_v;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      v_q <= '0;
    end else begin
      if (rdy[0]) v_q[0] <= IN_VALID;
      for (int k = 1; k < int'(STAGES); k++) begin
        if (rdy[k]) v_q[k] <= v_q[k-1];
      end
    end
  end

  if (STAGES == 1) begin : g_one
    logic [WIDTH-1:0] x_comb;
    assign x_comb = or_red & B1;

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        x_q <= '0;
      end else if (rdy[0] && IN_VALID) begin
        x_q <= x_comb;
      end
    end
  end else begin : g_two
    logic [WIDTH-1:0] or_q;
    logic [WIDTH-1:0] b_q;

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        or_q <= '0;
        b_q  <= '0;
      end else if (rdy[0] && IN_VALID) begin
        or_q <= or_red;
        b_q  <= B1;
      end
    end

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        x_q <= '0;
      end else if (rdy[1] && v_q[0]) begin
        x_q <= or_q & b_q;
      end
    end
  end

  assign X         = x_q;
  assign OUT_VALID = v_q[STAGES-1];
  assign IN_READY  = rdy[0];

`ifdef SCS8HD_O2XA_PIPE_CNT_EN
  logic [CNT_W-1:0] beats_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      beats_q <= '0;
    end else if (OUT_VALID && OUT_READY && (x_q != '0) && (beats_q != {CNT_W{1'b1}})) begin
      beats_q <= beats_q + 1'b1;
    end
  end

  assign BEATS = beats_q;
`endif

endmodule

// File: tb/tb_scs8hd_o2xa_pipe.sv
// Directed bench for scs8hd_o2xa_pipe: a narrow single-stage instance and a wide two-stage one.
module tb_scs8hd_o2xa_pipe;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  // Narrow instance: WIDTH=1, NOR=2, STAGES=1
  logic [1:0] n_a;
  logic [0:0] n_b;
  logic       n_iv, n_ir, n_ov, n_or;
  logic [0:0] n_x;

  // Wide instance: WIDTH=4, NOR=3, STAGES=2
  logic [11:0] w_a;
  logic [3:0]  w_b;
  logic        w_iv, w_ir, w_ov, w_or;
  logic [3:0]  w_x;

`ifdef SCS8HD_O2XA_PIPE_CNT_EN
  logic [1:0] n_beats, w_beats;
`endif

  int n_pass  = 0;
  int n_total = 0;

  scs8hd_o2xa_pipe #(.WIDTH(1), .NOR(2), .STAGES(1), .CNT_W(2)) u_narrow (
    .CLK      (CLK),
    .RESET    (RESET),
    .A        (n_a),
    .B1       (n_b),
    .IN_VALID (n_iv),
    .IN_READY (n_ir),
    .X        (n_x),
    .OUT_VALID(n_ov),
    .OUT_READY(n_or)
`ifdef SCS8HD_O2XA_PIPE_CNT_EN
    ,
    .BEATS    (n_beats)
`endif
  );

  scs8hd_o2xa_pipe #(.WIDTH(4), .NOR(3), .STAGES(2), .CNT_W(2)) u_wide (
    .CLK      (CLK),
    .RESET    (RESET),
    .A        (w_a),
    .B1       (w_b),
    .IN_VALID (w_iv),
    .IN_READY (w_ir),
    .X        (w_x),
    .OUT_VALID(w_ov),
    .OUT_READY(w_or)
`ifdef SCS8HD_O2XA_PIPE_CNT_EN
    ,
    .BEATS    (w_beats)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] a;
    logic       b;
    logic       x;
  } nvec_t;

  typedef struct {
    logic [11:0] a;
    logic [3:0]  b;
    logic [3:0]  x;
  } wvec_t;

  nvec_t ntv[8];
  wvec_t wtv[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int valid_seen;

    // Truth table for (A2|A1)&B1, a[0]=A1, a[1]=A2
    ntv[0] = '{2'b00, 1'b0, 1'b0};
    ntv[1] = '{2'b01, 1'b0, 1'b0};
    ntv[2] = '{2'b10, 1'b0, 1'b0};
    ntv[3] = '{2'b11, 1'b0, 1'b0};
    ntv[4] = '{2'b00, 1'b1, 1'b0};
    ntv[5] = '{2'b01, 1'b1, 1'b1};
    ntv[6] = '{2'b10, 1'b1, 1'b1};
    ntv[7] = '{2'b11, 1'b1, 1'b1};

    wtv[0] = '{12'h00F, 4'b1011, 4'b0011};
    wtv[1] = '{12'hFFF, 4'b0000, 4'b0000};
    wtv[2] = '{12'h924, 4'b0110, 4'b0110};
    wtv[3] = '{12'h1C0, 4'b1111, 4'b0100};

    // T1: reset held with traffic present
    n_a = 2'($urandom); n_b = 1'b1; n_iv = 1'b1; n_or = 1'b1;
    w_a = 12'($urandom); w_b = 4'hF; w_iv = 1'b1; w_or = 1'b1;
    step();
    step();
    check("t1_narrow_ov", 32'(n_ov), 32'd0);
    check("t1_narrow_x",  32'(n_x),  32'd0);
    check("t1_wide_ov",   32'(w_ov), 32'd0);
    check("t1_wide_x",    32'(w_x),  32'd0);
`ifdef SCS8HD_O2XA_PIPE_CNT_EN
    check("t1_wide_beats", 32'(w_beats), 32'd0);
`endif
    RESET = 1'b0;
    n_iv = 1'b0;
    w_iv = 1'b0;
    #1;
    check("t1_narrow_ir", 32'(n_ir), 32'd1);
    check("t1_wide_ir",   32'(w_ir), 32'd1);

    // T2: back-to-back truth table through the single-stage instance
    step();
    for (int i = 0; i < 8; i++) begin
      n_a  = ntv[i].a;
      n_b  = ntv[i].b;
      n_iv = 1'b1;
      check($sformatf("t2_ir_%0d", i), 32'(n_ir), 32'd1);
      step();
      check($sformatf("t2_ov_%0d", i), 32'(n_ov), 32'd1);
      check($sformatf("t2_x_%0d", i),  32'(n_x),  32'(ntv[i].x));
    end
    n_iv = 1'b0;
    step();
    check("t2_drain_ov", 32'(n_ov), 32'd0);

    // T3: wide stream, two-cycle latency, output for beat i-1 after edge i
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        w_a  = wtv[i].a;
        w_b  = wtv[i].b;
        w_iv = 1'b1;
      end else begin
        w_iv = 1'b0;
      end
      step();
      if (i == 0) begin
        check("t3_lat_ov", 32'(w_ov), 32'd0);
      end else if (i <= 4) begin
        check($sformatf("t3_ov_%0d", i - 1), 32'(w_ov), 32'd1);
        check($sformatf("t3_x_%0d", i - 1),  32'(w_x),  32'(wtv[i-1].x));
      end else begin
        check("t3_drain_ov", 32'(w_ov), 32'd0);
      end
    end

    // T4: backpressure with P, Q, R
    w_or = 1'b0;
    w_a = 12'hFFF; w_b = 4'hF; w_iv = 1'b1;          // P -> 1111
    check("t4_p_ir", 32'(w_ir), 32'd1);
    step();
    w_a = 12'h038; w_b = 4'hF;                        // Q -> 0010
    check("t4_q_ir", 32'(w_ir), 32'd1);
    step();
    check("t4_p_ov", 32'(w_ov), 32'd1);
    check("t4_p_x",  32'(w_x),  32'hF);
    w_a = 12'hE00; w_b = 4'h8;                        // R -> 1000
    check("t4_r_blocked", 32'(w_ir), 32'd0);
    step();
    check("t4_stall_ov", 32'(w_ov), 32'd1);
    check("t4_stall_x",  32'(w_x),  32'hF);
    check("t4_stall_ir", 32'(w_ir), 32'd0);
    w_or = 1'b1;
    #1;
    check("t4_r_ready", 32'(w_ir), 32'd1);
    step();
    w_iv = 1'b0;
    check("t4_q_ov", 32'(w_ov), 32'd1);
    check("t4_q_x",  32'(w_x),  32'h2);
    step();
    check("t4_r_ov", 32'(w_ov), 32'd1);
    check("t4_r_x",  32'(w_x),  32'h8);
    step();
    check("t4_empty_ov", 32'(w_ov), 32'd0);

    // T5: asynchronous reset with two beats in flight
    w_or = 1'b0;
    w_a = 12'hFFF; w_b = 4'hF; w_iv = 1'b1;
    step();
    w_a = 12'h007; w_b = 4'h1;
    step();
    w_iv = 1'b0;
    check("t5_full_ov", 32'(w_ov), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    check("t5_async_ov", 32'(w_ov), 32'd0);
    check("t5_async_x",  32'(w_x),  32'd0);
    #1;
    RESET = 1'b0;
    w_or = 1'b1;
    valid_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (w_ov) valid_seen++;
    end
    check("t5_no_ghost", 32'(valid_seen), 32'd0);

`ifdef SCS8HD_O2XA_PIPE_CNT_EN
    // T6: two zero beats then five non-zero beats; CNT_W=2 saturates at 3
    for (int i = 0; i < 10; i++) begin
      if (i < 2) begin
        w_a = 12'h000; w_b = 4'hF; w_iv = 1'b1;
      end else if (i < 7) begin
        w_a = 12'hFFF; w_b = 4'h1; w_iv = 1'b1;
      end else begin
        w_iv = 1'b0;
      end
      step();
      if (i == 4) check("t6_beats_mid", 32'(w_beats), 32'd1);
    end
    check("t6_beats_sat", 32'(w_beats), 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
